// File: rtl/perf_sample_ctrl.sv
// perf_sample_ctrl: periodic scanner that snapshots hpm counters 3..8 into a sample FIFO,
// sharing the counter-block port with the CSR file, which always wins.
package riscv;
   localparam int XLEN = 64;
   typedef logic [XLEN-1:0] xlen_t;
   localparam logic [11:0] CSR_MHPM_EVENT_3   = 12'h323;
   localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;
endpackage

module perf_sample_ctrl #(
   parameter int FifoDepth = 4,
   parameter int SeqWidth  = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic [15:0]         interval_i,
   input  logic [5:0]          mask_i,
   input  logic                csr_req_i,
   input  logic [11:0]         csr_addr_i,
   input  logic                csr_we_i,
   input  riscv::xlen_t        csr_wdata_i,
   output riscv::xlen_t        csr_rdata_o,
   output logic [11:0]         pc_addr_o,
   output logic                pc_we_o,
   output riscv::xlen_t        pc_wdata_o,
   input  riscv::xlen_t        pc_rdata_i,
   output logic                smp_valid_o,
   input  logic                smp_ready_i,
   output logic [2:0]          smp_idx_o,
   output logic [SeqWidth-1:0] smp_seq_o,
   output riscv::xlen_t        smp_data_o,
   output logic                busy_o,
   output logic                overrun_o,
   input  logic                overrun_clr_i
);
   localparam int PW = $clog2(FifoDepth);
   localparam int EW = 3 + SeqWidth + riscv::XLEN;
   localparam logic [PW:0] Full = (PW+1)'(FifoDepth);

   typedef enum logic {IDLE, SCAN} state_e;

   state_e              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [SeqWidth-1:0] seq_q, seq_d;
   logic [15:0]         tmr_q, tmr_d, tmr, tmr_dec;
   logic                init_q, ovr_q, ovr_d;
   logic [7:0]          m;
   logic                rd, adv, last, full, empty, pop;
   logic [EW-1:0]       mem [FifoDepth];
   logic [PW-1:0]       wptr, rptr;
   logic [PW:0]         cnt;

   // the timer reads interval_i until the first clock after reset release
   assign tmr     = init_q ? interval_i : tmr_q;
   assign tmr_dec = (tmr == '0) ? '0 : tmr - 16'd1;
   assign m       = {2'b00, mask_i};
   assign full    = cnt == Full;
   assign empty   = cnt == '0;
   assign pop     = !empty && smp_ready_i;
   assign rd      = state_q == SCAN && enable_i && m[idx_q] && !csr_req_i && !full;
   assign adv     = state_q == SCAN && enable_i && (!m[idx_q] || rd);
   assign last    = adv && idx_q == 3'd5;

   assign csr_rdata_o = csr_req_i ? pc_rdata_i : '0;
   assign pc_we_o     = csr_req_i && csr_we_i;
   assign pc_wdata_o  = csr_req_i ? csr_wdata_i : '0;
   assign pc_addr_o   = csr_req_i ? csr_addr_i : rd ? riscv::CSR_MHPM_COUNTER_3 + {9'd0, idx_q} : '0;
   assign busy_o      = state_q == SCAN;
   assign overrun_o   = ovr_q;
   assign smp_valid_o = !empty;
   assign {smp_idx_o, smp_seq_o, smp_data_o} = mem[rptr];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      tmr_d   = tmr_dec;
      ovr_d   = ovr_q && !overrun_clr_i;
      if (!enable_i) begin
         state_d = IDLE;
         tmr_d   = interval_i;
      end else if (state_q == IDLE) begin
         if (tmr == '0) begin
            state_d = SCAN;
            idx_d   = '0;
            tmr_d   = interval_i;
         end
      end else begin
         // the next period elapses before this scan finishes
         if (tmr <= 16'd1) ovr_d = 1'b1;
         if (last) begin
            state_d = IDLE;
            idx_d   = '0;
            seq_d   = seq_q + SeqWidth'(1);
            tmr_d   = interval_i;
         end else if (adv) begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         seq_q   <= '0;
         tmr_q   <= '0;
         init_q  <= 1'b1;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         tmr_q   <= tmr_d;
         init_q  <= 1'b0;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (rd) wptr <= wptr + PW'(1);
         if (pop) rptr <= rptr + PW'(1);
         cnt <= cnt + (PW+1)'(rd) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rd) mem[wptr] <= {idx_q, seq_q, pc_rdata_i};
   end
endmodule

// File: tb/tb_perf_sample_ctrl.sv
// tb_perf_sample_ctrl: scoreboard bench; expected samples are queued as scans are set up
// and compared whenever the sink accepts a sample.
module tb_perf_sample_ctrl;
   logic         clk = 0, rst_ni = 0, enable_i = 0, csr_req_i = 0, csr_we_i = 0;
   logic [15:0]  interval_i = 16'd3;
   logic [5:0]   mask_i = 6'h3F;
   logic [11:0]  csr_addr_i = '0, pc_addr_o;
   riscv::xlen_t csr_wdata_i = '0, csr_rdata_o, pc_wdata_o, pc_rdata_i, smp_data_o;
   logic         pc_we_o, smp_valid_o, smp_ready_i = 0, busy_o, overrun_o, overrun_clr_i = 0;
   logic [2:0]   smp_idx_o;
   logic [7:0]   smp_seq_o, exp_seq = '0;
   logic [74:0]  q[$];
   int           n_chk = 0, n_fail = 0, n, g;

   perf_sample_ctrl #(.FifoDepth(4), .SeqWidth(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .interval_i(interval_i), .mask_i(mask_i),
      .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
      .csr_rdata_o(csr_rdata_o), .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o),
      .pc_rdata_i(pc_rdata_i), .smp_valid_o(smp_valid_o), .smp_ready_i(smp_ready_i),
      .smp_idx_o(smp_idx_o), .smp_seq_o(smp_seq_o), .smp_data_o(smp_data_o), .busy_o(busy_o),
      .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
   );

   function automatic riscv::xlen_t f(input logic [11:0] a);
      return {20'hFACE0, 32'h1234_5678, a};
   endfunction

   assign pc_rdata_i = f(pc_addr_o);
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_scan(input logic [7:0] s, input logic [5:0] mk);
      for (int k = 0; k < 6; k++)
         if (mk[k]) q.push_back({3'(k), s, f(riscv::CSR_MHPM_COUNTER_3 + 12'(k))});
   endtask

   task automatic wait_busy(input string tag);
      for (int i = 0; i < 200 && !busy_o; i++) tick;
      check(tag, busy_o, 1);
   endtask

   task automatic scan_len(input string tag, output int len);
      wait_busy(tag);
      len = 1;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (!busy_o) break;
         len++;
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 300 && (q.size() != 0 || smp_valid_o); i++) tick;
      check(tag, {q.size() == 0, smp_valid_o}, 2'b10);
   endtask

   always @(negedge clk) begin
      if (rst_ni && smp_valid_o && smp_ready_i) begin
         if (q.size() == 0) check("sb_unexpected", {smp_idx_o, smp_seq_o, smp_data_o}, 0);
         else check("sample", {smp_idx_o, smp_seq_o, smp_data_o}, q.pop_front());
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_valid", smp_valid_o, 0);
      check("rst_ovr", overrun_o, 0);
      check("rst_addr", pc_addr_o, 0);
      check("rst_we", pc_we_o, 0);
      check("rst_rdata", csr_rdata_o, 0);
      rst_ni = 1;
      tick;
      // two back-to-back periodic scans, idle gap = interval+1
      smp_ready_i = 1;
      push_scan(exp_seq, 6'h3F);
      push_scan(8'(exp_seq + 1), 6'h3F);
      enable_i = 1;
      scan_len("t1_busy", n);
      check("t1_len0", n, 6);
      g = 1;
      for (int i = 0; i < 50; i++) begin
         tick;
         if (busy_o) break;
         g++;
      end
      check("t1_gap", g, 4);
      scan_len("t1_busy1", n);
      check("t1_len1", n, 6);
      enable_i = 0;
      exp_seq += 2;
      wait_drain("t1_drain");
      // CSR access steals the port mid-scan
      push_scan(exp_seq, 6'h3F);
      enable_i = 1;
      wait_busy("t2_busy");
      n = 1;
      tick;
      tick;
      n = 3;
      csr_req_i = 1;
      csr_we_i = 1;
      csr_addr_i = riscv::CSR_MHPM_EVENT_3;
      csr_wdata_i = 64'hDEAD_BEEF_0000_0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_we", pc_we_o, 1);
         check("t2_addr", pc_addr_o, riscv::CSR_MHPM_EVENT_3);
         check("t2_wdata", pc_wdata_o, 64'hDEAD_BEEF_0000_0001);
         check("t2_rdata", csr_rdata_o, f(riscv::CSR_MHPM_EVENT_3));
         tick;
         n++;
      end
      csr_req_i = 0;
      csr_we_i = 0;
      for (int i = 0; i < 20; i++) begin
         if (!busy_o) break;
         tick;
         if (busy_o) n++;
      end
      check("t2_len", n, 9);
      enable_i = 0;
      exp_seq++;
      wait_drain("t2_drain");
      // sparse mask, then FIFO-full stall at idx 4
      smp_ready_i = 0;
      interval_i = 16'd20;
      mask_i = 6'b100001;
      push_scan(exp_seq, mask_i);
      tick;
      enable_i = 1;
      scan_len("t3_busy", n);
      check("t3_len", n, 6);
      enable_i = 0;
      exp_seq++;
      check("t3_valid", smp_valid_o, 1);
      smp_ready_i = 1;
      wait_drain("t3_drain");
      smp_ready_i = 0;
      mask_i = 6'h3F;
      push_scan(exp_seq, mask_i);
      tick;
      enable_i = 1;
      wait_busy("t3_busy1");
      repeat (10) tick;
      check("t3_stall_busy", busy_o, 1);
      check("t3_stall_addr", pc_addr_o, 0);
      smp_ready_i = 1;
      tick;
      smp_ready_i = 0;
      check("t3_idx4_addr", pc_addr_o, riscv::CSR_MHPM_COUNTER_3 + 12'd4);
      smp_ready_i = 1;
      for (int i = 0; i < 50 && busy_o; i++) tick;
      check("t3_done", busy_o, 0);
      enable_i = 0;
      exp_seq++;
      wait_drain("t3_drain1");
      // overrun: set, set-wins on clear, clear
      smp_ready_i = 0;
      interval_i = 16'd0;
      overrun_clr_i = 1;
      tick;
      overrun_clr_i = 0;
      check("t4_ovr_clr0", overrun_o, 0);
      push_scan(exp_seq, 6'h0F);
      enable_i = 1;
      wait_busy("t4_busy");
      tick;
      check("t4_ovr_set", overrun_o, 1);
      repeat (5) tick;
      check("t4_stall", busy_o, 1);
      overrun_clr_i = 1;
      tick;
      overrun_clr_i = 0;
      check("t4_set_wins", overrun_o, 1);
      enable_i = 0;
      tick;
      check("t4_abort", busy_o, 0);
      overrun_clr_i = 1;
      tick;
      overrun_clr_i = 0;
      check("t4_ovr_clr", overrun_o, 0);
      smp_ready_i = 1;
      wait_drain("t4_drain");
      // abort at idx 2; seq must not advance
      smp_ready_i = 0;
      interval_i = 16'd3;
      push_scan(exp_seq, 6'h03);
      enable_i = 1;
      wait_busy("t5_busy");
      tick;
      tick;
      enable_i = 0;
      tick;
      check("t5_idle", busy_o, 0);
      check("t5_valid", smp_valid_o, 1);
      smp_ready_i = 1;
      wait_drain("t5_drain");
      push_scan(exp_seq, 6'h3F);
      enable_i = 1;
      scan_len("t5_busy1", n);
      check("t5_len", n, 6);
      enable_i = 0;
      exp_seq++;
      wait_drain("t5_drain1");
      // asynchronous reset mid-scan with three queued
      smp_ready_i = 0;
      enable_i = 1;
      wait_busy("t6_busy");
      repeat (3) tick;
      check("t6_valid", smp_valid_o, 1);
      #2 rst_ni = 0;
      #1;
      check("t6_rst_valid", smp_valid_o, 0);
      check("t6_rst_busy", busy_o, 0);
      enable_i = 0;
      q.delete();
      tick;
      rst_ni = 1;
      tick;
      smp_ready_i = 1;
      push_scan(8'd0, 6'h3F);
      enable_i = 1;
      scan_len("t6_busy1", n);
      check("t6_len", n, 6);
      enable_i = 0;
      wait_drain("t6_drain");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/perf_sample_ctrl.md
PERF_SAMPLE_CTRL -- requirements
Module: perf_sample_ctrl

Interface
REQ-001 SHALL have parameter FifoDepth, default 4, sample FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter SeqWidth, default 8, width of the scan sequence tag.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  periodic sampling enable.
REQ-006 SHALL have port interval_i  input  16  idle cycles between scans.
REQ-007 SHALL have port mask_i  input  6  bit k selects counter k+3 for sampling.
REQ-008 SHALL have port csr_req_i  input  1  CSR-file access valid this cycle.
REQ-009 SHALL have port csr_addr_i  input  12  CSR address.
REQ-010 SHALL have port csr_we_i  input  1  CSR write enable.
REQ-011 SHALL have port csr_wdata_i  input  riscv::xlen_t  CSR write data.
REQ-012 SHALL have port csr_rdata_o  output  riscv::xlen_t  CSR read data.
REQ-013 SHALL have port pc_addr_o  output  12  counter-block address.
REQ-014 SHALL have port pc_we_o  output  1  counter-block write enable.
REQ-015 SHALL have port pc_wdata_o  output  riscv::xlen_t  counter-block write data.
REQ-016 SHALL have port pc_rdata_i  input  riscv::xlen_t  counter-block combinational read data.
REQ-017 SHALL have port smp_valid_o  output  1  sample available.
REQ-018 SHALL have port smp_ready_i  input  1  sink accepts sample.
REQ-019 SHALL have port smp_idx_o  output  3  counter index 0..5 (counter 3..8).
REQ-020 SHALL have port smp_seq_o  output  SeqWidth  scan tag of sample.
REQ-021 SHALL have port smp_data_o  output  riscv::xlen_t  sampled value.
REQ-022 SHALL have port busy_o  output  1  high while in SCAN.
REQ-023 SHALL have port overrun_o  output  1  sticky missed-scan flag.
REQ-024 SHALL have port overrun_clr_i  input  1  clears overrun_o.

Function
REQ-025 SHALL give the CSR absolute priority: csr_req_i=1 -> pc_addr_o=csr_addr_i, pc_we_o=csr_we_i, pc_wdata_o=csr_wdata_i, csr_rdata_o=pc_rdata_i, combinationally.
REQ-026 SHALL drive csr_rdata_o=0 and pc_we_o=0 when csr_req_i=0; pc_wdata_o=0 whenever sampler owns the port.
REQ-027 SHALL implement FSM IDLE/SCAN; busy_o=1 exactly in SCAN.
REQ-028 SHALL, in IDLE with enable_i=1: timer==0 -> SCAN with idx=0 next cycle; else timer decrements by 1.
REQ-029 SHALL load timer with interval_i on reset release, on entry to IDLE, and whenever enable_i=0 (interval_i=0 -> scan every scan-completion+1 cycle).
REQ-030 SHALL, in SCAN with mask_i[idx]=0, advance idx by 1 in one cycle with no port use.
REQ-031 SHALL, in SCAN with mask_i[idx]=1, csr_req_i=0 and FIFO not full, drive pc_addr_o=riscv::CSR_MHPM_COUNTER_3+idx, push {idx, seq, pc_rdata_i} same cycle, advance idx.
REQ-032 SHALL hold idx (stall) when mask_i[idx]=1 and csr_req_i=1 or FIFO full; full blocks push even if a pop occurs that cycle.
REQ-033 SHALL, when advancing from idx=5, return to IDLE and increment seq modulo 2^SeqWidth.
REQ-034 SHALL drive pc_addr_o=0 when no CSR request and sampler not reading.
REQ-035 SHALL abort SCAN to IDLE when enable_i=0; FIFO contents kept, seq unchanged.
REQ-036 SHALL set overrun_o when timer would reach 0 during SCAN (timer keeps decrementing in SCAN, saturating at 0); overrun_clr_i clears, set wins on simultaneous set/clear.
REQ-037 SHALL present FIFO head on smp_* with smp_valid_o=!empty; pop on smp_valid_o&&smp_ready_i; first-in first-out.

Reset
REQ-038 SHALL on rst_ni=0 asynchronously set FSM=IDLE, idx=0, seq=0, FIFO empty, overrun_o=0, busy_o=0, smp_valid_o=0, timer=interval_i at release.

Verification
REQ-039 interval_i=3, mask_i=6'h3F, enable_i=1, ready=1, no CSR -> six samples idx 0..5, seq 0, busy_o high 6 cycles, next scan seq 1.
REQ-040 csr_req_i=1 with csr_we_i=1, addr=CSR_MHPM_EVENT_3 during SCAN -> pc_we_o=1, pc_addr_o=csr_addr_i, idx frozen for those cycles.
REQ-041 mask_i=6'b100001, ready=0, FifoDepth=4 -> two samples idx 0,5; with mask 6'h3F scan stalls at idx 4 until one pop.
REQ-042 interval_i=0, ready=0 -> scan stalls, timer hits 0 -> overrun_o=1; overrun_clr_i pulse -> 0 unless set same cycle.
REQ-043 enable_i dropped mid-scan at idx 2 -> IDLE next cycle, busy_o=0, queued samples still drain in order.
REQ-044 rst_ni asserted mid-scan with 3 queued -> smp_valid_o=0, busy_o=0, seq=0 immediately.
